// File: rtl/conv_pkg.sv
// Shared constants and helpers for the rate-1/2, K=3 convolutional code (generators 111 / 101).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package conv_pkg;

    localparam logic [2:0] G0      = 3'b111;
    localparam logic [2:0] G1      = 3'b101;
    localparam int         K       = 3;
    localparam int         NSTATES = 4;

    // Encoder output for input bit x leaving state s = {x[n-1], x[n-2]}.
    function automatic logic [1:0] exp_sym(input logic x, input logic [1:0] s);
        logic [2:0] r;
        r = {x, s};
        return {^(r & G0), ^(r & G1)};
    endfunction

    // Hamming distance between two 2-bit symbols (0..2).
    function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] d;
        d = a ^ b;
        return {1'b0, d[1]} + {1'b0, d[0]};
    endfunction

endpackage

// File: rtl/conv_acs.sv
// One add-compare-select unit: two saturating candidate metrics, keep the smaller.
// Latency: combinational.
// Backpressure: none.
module conv_acs #(
    parameter int PM_W = 5
) (
    input  logic [PM_W-1:0] pm0,
    input  logic [PM_W-1:0] pm1,
    input  logic [1:0]      bm0,
    input  logic [1:0]      bm1,
    output logic [PM_W-1:0] pm_new,
    output logic            sel
);

    logic [PM_W:0]   sum0;
    logic [PM_W:0]   sum1;
    logic [PM_W-1:0] cand0;
    logic [PM_W-1:0] cand1;

    // Saturating add of both candidates, then pick the smaller; ties go to predecessor 0.
    always_comb begin
        sum0  = {1'b0, pm0} + {{(PM_W-1){1'b0}}, bm0};
        sum1  = {1'b0, pm1} + {{(PM_W-1){1'b0}}, bm1};
        cand0 = sum0[PM_W] ? {PM_W{1'b1}} : sum0[PM_W-1:0];
        cand1 = sum1[PM_W] ? {PM_W{1'b1}} : sum1[PM_W-1:0];
        sel    = (cand1 < cand0);
        pm_new = sel ? cand1 : cand0;
    end

endmodule

// File: rtl/conv_dec.sv
// Hard-decision Viterbi decoder, K=3 rate-1/2, register-exchange survivors; optional err_cnt via CONV_DEC_ERRCNT_EN.
// Latency: decoded bit n appears the cycle after symbol n+TB_DEPTH is accepted.
// Backpressure: none; one symbol accepted on every cycle in_valid is high.
module conv_dec
    import conv_pkg::*;
#(
    parameter int TB_DEPTH = 15,
    parameter int PM_W     = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [1:0]  z,
    output logic        out_valid,
    output logic        y
`ifdef CONV_DEC_ERRCNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    localparam int CW = $clog2(TB_DEPTH + 1);

    logic [PM_W-1:0]     pm       [NSTATES];
    logic [TB_DEPTH-1:0] surv     [NSTATES];
    logic [PM_W-1:0]     acs_pm   [NSTATES];
    logic                acs_sel  [NSTATES];
    logic [TB_DEPTH-1:0] surv_nxt [NSTATES];
    logic [CW-1:0]       cnt;
    logic [PM_W-1:0]     min_new;
    logic [PM_W-1:0]     best_pm;
    logic [1:0]          best;

    // State t = {x, x[n-1]} is reached from {x[n-1],0} and {x[n-1],1} with input x = t[1].
    for (genvar t = 0; t < NSTATES; t++) begin : g_acs
        localparam logic [1:0] TS = 2'(t);
        localparam logic [1:0] P0 = {TS[0], 1'b0};
        localparam logic [1:0] P1 = {TS[0], 1'b1};

        conv_acs #(.PM_W(PM_W)) u_acs (
            .pm0    (pm[P0]),
            .pm1    (pm[P1]),
            .bm0    (hamming(z, exp_sym(TS[1], P0))),
            .bm1    (hamming(z, exp_sym(TS[1], P1))),
            .pm_new (acs_pm[t]),
            .sel    (acs_sel[t])
        );

        assign surv_nxt[t] = {TS[1], acs_sel[t] ? surv[P1][TB_DEPTH-1:1]
                                                : surv[P0][TB_DEPTH-1:1]};
    end

    // Minimum of the new metrics (normaliser) and lowest-index best state before the update.
    always_comb begin
        min_new = acs_pm[0];
        best_pm = pm[0];
        best    = 2'd0;
        for (int i = 1; i < NSTATES; i++) begin
            if (acs_pm[i] < min_new) min_new = acs_pm[i];
            if (pm[i] < best_pm) begin
                best_pm = pm[i];
                best    = 2'(i);
            end
        end
    end

    // Path metrics and survivors advance only on accepted symbols.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NSTATES; i++) begin
                pm[i]   <= (i == 0) ? '0 : PM_W'(4);
                surv[i] <= '0;
            end
        end else if (in_valid) begin
            for (int i = 0; i < NSTATES; i++) begin
                pm[i]   <= acs_pm[i] - min_new;
                surv[i] <= surv_nxt[i];
            end
        end
    end

    // Symbol counter saturating at TB_DEPTH gates the output; output taken from the pre-update best state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            out_valid <= 1'b0;
            y         <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            y         <= 1'b0;
            if (in_valid) begin
                if (cnt == CW'(TB_DEPTH)) begin
                    out_valid <= 1'b1;
                    y         <= surv[best][0];
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

`ifdef CONV_DEC_ERRCNT_EN
    logic [16:0] err_sum;
    assign err_sum = {1'b0, err_cnt} + 17'(min_new);

    // Accumulate the pre-normalisation best metric, saturating at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
        end else if (in_valid) begin
            err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_conv_dec.sv
module tb_conv_dec;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] z = 2'b00;
    logic       out_valid;
    logic       y;
`ifdef CONV_DEC_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    conv_dec #(.TB_DEPTH(15), .PM_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .z         (z),
        .out_valid (out_valid),
        .y         (y)
`ifdef CONV_DEC_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] z;
        logic       vld;
        logic       y;
    } vec_t;

    localparam int NSYM = 23;
    vec_t vec [NSYM];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Present one cycle of input at a negedge; return at the following negedge.
    task automatic apply(input logic v, input logic [1:0] zz);
        in_valid = v;
        z        = zz;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check({tag, "_rst_vld"}, 32'(out_valid), 32'd0);
        check({tag, "_rst_y"}, 32'(y), 32'd0);
`ifdef CONV_DEC_ERRCNT_EN
        check({tag, "_rst_err"}, 32'(err_cnt), 32'd0);
`endif
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Feed the reference stream; corrupt one symbol if requested; idle gap cycles after each symbol.
    task automatic run_stream(input string tag, input int corrupt_idx, input int gap);
        logic [1:0] zz;
        for (int n = 0; n < NSYM; n++) begin
            zz = vec[n].z;
            if (n == corrupt_idx) zz = 2'b01;
            apply(1'b1, zz);
            check($sformatf("%s_vld%0d", tag, n), 32'(out_valid), 32'(vec[n].vld));
            check($sformatf("%s_y%0d", tag, n), 32'(y), 32'(vec[n].y));
            for (int g = 0; g < gap; g++) begin
                apply(1'b0, 2'b00);
                check($sformatf("%s_idle%0d_%0d", tag, n, g), 32'(out_valid), 32'd0);
            end
        end
    endtask

    initial begin
        logic [1:0] syms [NSYM];
        logic [7:0] data;
        int         nout;
        logic       anyy;
        logic       zero_ok;
        logic       mono_ok;
        logic [15:0] prev;

        // Data 1,1,0,1,1,1,0,1 encoded from state 0, two tail symbols, then 13 zero symbols.
        data = 8'b1011_1011;  // bit i = data bit i
        for (int n = 0; n < NSYM; n++) syms[n] = 2'b00;
        syms[0] = 2'b11; syms[1] = 2'b01; syms[2] = 2'b01; syms[3] = 2'b00;
        syms[4] = 2'b01; syms[5] = 2'b10; syms[6] = 2'b01; syms[7] = 2'b00;
        syms[8] = 2'b10; syms[9] = 2'b11;
        for (int n = 0; n < NSYM; n++) begin
            vec[n].z   = syms[n];
            vec[n].vld = (n >= 15);
            vec[n].y   = (n >= 15) ? data[n-15] : 1'b0;
        end

        @(negedge clk);
        do_reset("init");

        // Clean stream
        run_stream("clean", -1, 0);
`ifdef CONV_DEC_ERRCNT_EN
        check("clean_err", 32'(err_cnt), 32'd0);
`endif

        // Single channel error on symbol 3
        do_reset("corr");
        run_stream("corr", 3, 0);
`ifdef CONV_DEC_ERRCNT_EN
        check("corr_err", 32'(err_cnt), 32'd1);
`endif

        // Three idle cycles after every symbol
        do_reset("gap");
        run_stream("gap", -1, 3);

        // 40 zero symbols
        do_reset("zero");
        nout = 0; anyy = 1'b0; zero_ok = 1'b1;
        for (int n = 0; n < 40; n++) begin
            apply(1'b1, 2'b00);
            if (out_valid) nout++;
            if (y) anyy = 1'b1;
            if (dut.pm[0] != 0) zero_ok = 1'b0;
        end
        check("zero_nout", 32'(nout), 32'd25);
        check("zero_y", 32'(anyy), 32'd0);
        check("zero_pm0", 32'(zero_ok), 32'd1);
`ifdef CONV_DEC_ERRCNT_EN
        check("zero_err", 32'(err_cnt), 32'd0);
`endif

        // Reset mid-stream after 10 symbols, then the clean stream must decode exactly
        do_reset("mid");
        for (int n = 0; n < 10; n++) apply(1'b1, 2'b11);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_vld0", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("mid_rst_vld1", 32'(out_valid), 32'd0);
        check("mid_rst_pm1", 32'(dut.pm[1]), 32'd4);
        rst = 1'b1;
        @(negedge clk);
        run_stream("mid", -1, 0);

        // 60 symbols of 11: normalisation keeps a zero metric, counter never decreases
        do_reset("ones");
        nout = 0; zero_ok = 1'b1; mono_ok = 1'b1; prev = '0;
        for (int n = 0; n < 60; n++) begin
            apply(1'b1, 2'b11);
            if (out_valid) nout++;
            if (dut.pm[0] != 0 && dut.pm[1] != 0 && dut.pm[2] != 0 && dut.pm[3] != 0)
                zero_ok = 1'b0;
`ifdef CONV_DEC_ERRCNT_EN
            if (err_cnt < prev) mono_ok = 1'b0;
            prev = err_cnt;
`endif
        end
        check("ones_nout", 32'(nout), 32'd45);
        check("ones_minpm", 32'(zero_ok), 32'd1);
        check("ones_mono", 32'(mono_ok), 32'd1);
`ifdef CONV_DEC_ERRCNT_EN
        check("ones_err_nz", 32'(err_cnt != 16'd0), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_dec.md
CONV_DEC -- requirements
Module: conv_dec

Interface
REQ-001 Parameter TB_DEPTH, default 15, survivor depth in bits and decode latency in accepted symbols; legal range 5..32.
REQ-002 Parameter PM_W, default 5, path-metric width in bits; legal range 3..8.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  a code symbol is present on z this cycle.
REQ-006 z  input  2  received hard-decision symbol: z[1] from generator 111, z[0] from generator 101.
REQ-007 out_valid  output  1  y holds a decoded bit this cycle.
REQ-008 y  output  1  decoded data bit.
REQ-009 err_cnt  output  16  accumulated channel-error estimate; present only with CONV_DEC_ERRCNT_EN.

Function
REQ-010 The decoder SHALL be a hard-decision Viterbi decoder for the rate-1/2, K=3 code: encoder state {x[n-1],x[n-2]}, z[1]=x^x[n-1]^x[n-2], z[0]=x^x[n-2], encoder start state 0.
REQ-011 Branch metric SHALL be the Hamming distance (0..2) between z and the branch's expected symbol.
REQ-012 On each edge with in_valid=1, all 4 path metrics SHALL update by add-compare-select; tie picks the predecessor with the lower state index.
REQ-013 After each ACS step, the minimum new metric SHALL be subtracted from all 4 metrics, so the best metric is always 0.
REQ-014 Metrics SHALL saturate at 2^PM_W-1 and never wrap.
REQ-015 Survivors SHALL use register exchange: each state holds TB_DEPTH decided bits, and the new bit is the state's MSB (newest x).
REQ-016 With in_valid=0, metrics, survivors and counters SHALL hold, and out_valid SHALL be 0 the next cycle.
REQ-017 A saturating counter SHALL count accepted symbols since reset.
REQ-018 On the edge accepting symbol n, with n>=TB_DEPTH, out_valid<=1 and y<=oldest survivor bit of the pre-update minimum-metric state, lowest index on tie; y is then decoded bit n-TB_DEPTH.
REQ-019 For n<TB_DEPTH, out_valid<=0 and y<=0.
REQ-020 The decoder SHALL have no backpressure; it accepts one symbol every cycle that in_valid is 1.
REQ-021 Trailing bits SHALL be flushed only by the user appending at least TB_DEPTH further symbols.

Reset
REQ-022 While rst=0: metric of state 0 is 0, metrics of states 1..3 are 4, survivors are all-zero, symbol counter is 0, out_valid=0, y=0, err_cnt=0.
REQ-023 Reset asserted mid-stream SHALL discard all history; the first symbol after release is symbol 0.

Configuration
REQ-024 With macro CONV_DEC_ERRCNT_EN defined, err_cnt SHALL add the pre-normalisation minimum metric on every accepted symbol, saturating at 16'hFFFF.
REQ-025 Without CONV_DEC_ERRCNT_EN, port err_cnt and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 Package conv_pkg SHALL hold the generator constants G0=3'b111 and G1=3'b101, the constraint length K=3, the state count 4, and the expected-symbol function shared with conv_enc.
REQ-027 Sub-module conv_acs SHALL implement one add-compare-select unit, instantiated once per state.

Verification
REQ-028 Data 1,1,0,1,1,1,0,1 encoded as symbols 11,01,01,00,01,10,01,00, then 10,11 and 13x 00, fed back-to-back -> the first 8 out_valid bits are y=1,1,0,1,1,1,0,1; the first out_valid occurs the cycle after symbol 15 is accepted.
REQ-029 Same stream with symbol 3 corrupted to 01 -> identical y sequence; err_cnt=1 (with CONV_DEC_ERRCNT_EN).
REQ-030 Same stream with in_valid deasserted for 3 cycles after every symbol -> identical y sequence; out_valid is high only on cycles after accepting edges.
REQ-031 40 symbols of 00 -> 25 outputs, all y=0; the state-0 metric stays 0 and err_cnt stays 0.
REQ-032 rst pulsed low after 10 symbols, then the REQ-028 stream is fed -> out_valid=0 during reset; output matches REQ-028 exactly.
REQ-033 60 symbols of 11 -> no metric exceeds 2^PM_W-1; err_cnt is monotonic and saturating.
